// File: rtl/t_toggle_arbiter_if.sv
// Requester-side bus of the toggle arbiter: requests and masks in,
// one-hot grant and one-cycle completion ack out.
interface t_toggle_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;

  modport master (
    output req, mask,
    input  gnt, ack
  );

  modport slave (
    input  req, mask,
    output gnt, ack
  );
endinterface

// File: rtl/t_toggle_arbiter.sv
// Round-robin sequencer sharing one toggle register between NREQ requesters.
// Ports: clk, rst (async high), enable, clr, bus (req/mask/gnt/ack), q, busy.
module t_toggle_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr,
  t_toggle_arbiter_if.slave bus,
  output logic [WIDTH-1:0]  q,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    APPLY
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  mask_q, mask_d;

  logic [NREQ-1:0]   cand;
  logic              found;
  logic [IW-1:0]     pick;
  logic [WIDTH-1:0]  pick_mask;

  // In APPLY the just-served requester is still holding req;
  // it must drop out so it re-enters as a fresh request.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand[i] = bus.req[i] &&
                !(state_q == APPLY && win_q == IW'(i));
    end
  end

  // Search upward from the pointer with wrap.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign pick_mask = bus.mask[pick*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    q_d     = q_q;
    mask_d  = mask_q;

    unique case (state_q)
      IDLE: begin
        if (enable && found) begin
          gnt_d   = NREQ'(1) << pick;
          win_d   = pick;
          mask_d  = pick_mask;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (enable) begin
          q_d     = q_q ^ mask_q;
          ack_d   = gnt_q;
          gnt_d   = '0;
          ptr_d   = (win_q == IW'(NREQ - 1)) ? '0
                                             : win_q + IW'(1);
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = IDLE;
        if (enable && found) begin
          gnt_d   = NREQ'(1) << pick;
          win_d   = pick;
          mask_d  = pick_mask;
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // Clear wins over a coincident toggle; the ack still goes out.
    if (clr) q_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign q       = q_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_t_toggle_arbiter.sv
// Self-checking bench for t_toggle_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_t_toggle_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;

  t_toggle_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  t_toggle_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clr    (clr),
    .bus    (bus),
    .q      (q),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase 0 = no transaction, 1 = granted, 2 = just acked.
  int               m_ph;
  int               m_win;
  int               m_ptr;
  logic [WIDTH-1:0] m_mask;
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  logic [NREQ-1:0]  m_ack;

  function automatic int pick(logic [NREQ-1:0] r, int ptr, int excl);
    int best = -1;
    int bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && i != excl) begin
        int d = (i - ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_win = 0; m_ptr = 0;
    m_mask = '0; m_q = '0; m_gnt = '0; m_ack = '0;
  endtask

  task automatic model_edge(logic en, logic cl, logic [NREQ-1:0] r,
                            logic [NREQ*WIDTH-1:0] mk);
    logic [WIDTH-1:0] nq;
    int w;
    nq = m_q;
    m_ack = '0;
    case (m_ph)
      0: if (en) begin
        w = pick(r, m_ptr, -1);
        if (w >= 0) begin
          m_win = w; m_mask = mk[w*WIDTH +: WIDTH]; m_ph = 1;
        end
      end
      1: if (en) begin
        nq = nq ^ m_mask;
        m_ack = NREQ'(1 << m_win);
        m_ptr = (m_win + 1) % NREQ;
        m_ph = 2;
      end
      default: begin
        m_ph = 0;
        if (en) begin
          w = pick(r, m_ptr, m_win);
          if (w >= 0) begin
            m_win = w; m_mask = mk[w*WIDTH +: WIDTH]; m_ph = 1;
          end
        end
      end
    endcase
    if (cl) nq = '0;
    m_q = nq;
    m_gnt = (m_ph == 1) ? NREQ'(1 << m_win) : '0;
  endtask

  // One clock: sample the inputs in force at the edge, advance the model,
  // and return #1 after the edge so outputs can be compared.
  task automatic step();
    logic en_s, cl_s, rst_s;
    logic [NREQ-1:0] r_s;
    logic [NREQ*WIDTH-1:0] mk_s;
    en_s = enable; cl_s = clr; rst_s = rst;
    r_s = bus.req; mk_s = bus.mask;
    @(posedge clk);
    #1;
    if (rst_s) model_reset();
    else model_edge(en_s, cl_s, r_s, mk_s);
  endtask

  task automatic set_mask(int i, logic [WIDTH-1:0] v);
    bus.mask[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.mask = '0;
    rst = 1'b1;
    model_reset();
    #1;
    n_total++;
    if ({bus.gnt, bus.ack, q, busy} !== '0)
      $display("FAIL reset_outs got=%h exp=0", {bus.gnt, bus.ack, q, busy});
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_total++;
    if ({bus.gnt, bus.ack, q, busy} !== '0)
      $display("FAIL reset_idle got=%h exp=0", {bus.gnt, bus.ack, q, busy});
    else n_pass++;
  endtask

  task automatic test_single();
    set_mask(0, 8'h0F);
    bus.req = 4'b0001;
    step();
    n_total++;
    if (bus.gnt !== 4'b0001 || busy !== 1'b1)
      $display("FAIL single_gnt got=%b/%b exp=0001/1", bus.gnt, busy);
    else n_pass++;
    step();
    n_total++;
    if (bus.ack !== 4'b0001 || q !== 8'h0F || bus.gnt !== 4'b0000)
      $display("FAIL single_ack got=%b q=%h exp=0001 q=0f", bus.ack, q);
    else n_pass++;
    bus.req = 4'b0000;
    step();
    step();
    bus.req = 4'b0001;
    step();
    step();
    n_total++;
    if (bus.ack !== 4'b0001 || q !== 8'h00)
      $display("FAIL single_second got=%b q=%h exp=0001 q=00", bus.ack, q);
    else n_pass++;
    bus.req = 4'b0000;
    step();
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] eq;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_mask(i, WIDTH'(1 << i));
    bus.req = 4'b1111;
    eq = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_total++;
      if (bus.gnt !== NREQ'(1 << (k % NREQ)) || bus.ack !== '0)
        $display("FAIL rr_gnt%0d got=%b exp=%b", k, bus.gnt,
                 NREQ'(1 << (k % NREQ)));
      else n_pass++;
      step();
      eq = eq ^ WIDTH'(1 << (k % NREQ));
      n_total++;
      if (bus.ack !== NREQ'(1 << (k % NREQ)) || q !== eq || bus.gnt !== '0)
        $display("FAIL rr_ack%0d got=%b q=%h exp=%b q=%h", k, bus.ack, q,
                 NREQ'(1 << (k % NREQ)), eq);
      else n_pass++;
    end
    bus.req = '0;
    step();
  endtask

  task automatic test_enable_stall();
    logic [WIDTH-1:0] q0;
    do_reset();
    set_mask(2, 8'h3C);
    bus.req = 4'b0100;
    q0 = m_q;
    step();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_total++;
      if (bus.gnt !== 4'b0100 || bus.ack !== '0 || q !== q0)
        $display("FAIL stall%0d got=%b/%b q=%h exp=0100/0000 q=%h",
                 k, bus.gnt, bus.ack, q, q0);
      else n_pass++;
    end
    enable = 1'b1;
    step();
    n_total++;
    if (bus.ack !== 4'b0100 || q !== (q0 ^ 8'h3C))
      $display("FAIL stall_done got=%b q=%h exp=0100 q=%h",
               bus.ack, q, q0 ^ 8'h3C);
    else n_pass++;
    bus.req = '0;
    step();
  endtask

  task automatic test_mask_change();
    logic [WIDTH-1:0] q0;
    q0 = m_q;
    set_mask(1, 8'hAA);
    bus.req = 4'b0010;
    step();
    set_mask(1, 8'h55);
    bus.req = 4'b0000;
    step();
    n_total++;
    if (bus.ack !== 4'b0010 || q !== (q0 ^ 8'hAA))
      $display("FAIL mask_change got=%b q=%h exp=0010 q=%h",
               bus.ack, q, q0 ^ 8'hAA);
    else n_pass++;
    step();
  endtask

  task automatic test_clr_collision();
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_mask(3, 8'hFF);
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0000;
    step();
    n_total++;
    if (q !== 8'hFF)
      $display("FAIL clr_setup got=%h exp=ff", q);
    else n_pass++;
    step();
    set_mask(0, 8'h01);
    bus.req = 4'b0001;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    bus.req = 4'b0000;
    n_total++;
    if (bus.ack !== 4'b0001 || q !== 8'h00)
      $display("FAIL clr_collision got=%b q=%h exp=0001 q=00", bus.ack, q);
    else n_pass++;
    step();
  endtask

  task automatic test_async_reset();
    set_mask(1, 8'h11);
    set_mask(3, 8'h80);
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    step();
    bus.req = 4'b1000;
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_total++;
    if ({bus.gnt, bus.ack, q, busy} !== '0)
      $display("FAIL async_rst got=%h exp=0", {bus.gnt, bus.ack, q, busy});
    else n_pass++;
    rst = 1'b0;
    bus.req = 4'b1010;
    step();
    n_total++;
    if (bus.gnt !== 4'b0010 || bus.ack !== '0)
      $display("FAIL async_ptr got=%b exp=0010", bus.gnt);
    else n_pass++;
    bus.req = 4'b0000;
    step();
    n_total++;
    if (bus.ack !== 4'b0010 || q !== 8'h11)
      $display("FAIL async_after got=%b q=%h exp=0010 q=11", bus.ack, q);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    int bad = 0;
    int badinv = 0;
    for (int c = 0; c < 600; c++) begin
      enable   = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 19) == 0);
      bus.req  = NREQ'($urandom);
      bus.mask = (NREQ*WIDTH)'($urandom);
      step();
      if ({bus.gnt, bus.ack, q, busy} !== {m_gnt, m_ack, m_q, (m_ph != 0)}) begin
        if (bad < 5)
          $display("FAIL rand_cyc%0d got=%b/%b/%h/%b exp=%b/%b/%h/%b", c,
                   bus.gnt, bus.ack, q, busy, m_gnt, m_ack, m_q, (m_ph != 0));
        bad++;
      end
      if (!$onehot0(bus.gnt) || !$onehot0(bus.ack) ||
          (|bus.gnt && |bus.ack))
        badinv++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rand_model got=%0d exp=0 bad cycles", bad);
    else n_pass++;
    n_total++;
    if (badinv != 0)
      $display("FAIL rand_onehot got=%0d exp=0 bad cycles", badinv);
    else n_pass++;
    enable = 1'b1; clr = 1'b0; bus.req = '0;
    step();
    step();
  endtask

  initial begin
    bus.req  = '0;
    bus.mask = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_enable_stall();
    test_mask_change();
    test_clr_collision();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/t_toggle_arbiter.md
Name: t_toggle_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit bank of T flip-flops (toggle register) between NREQ requesters.
- Each requester presents a toggle mask; the winner's mask is XOR-applied to the shared register in a single update, and the winner receives an ack pulse.
- Sits between the request sources and the shared toggle storage, replacing ad-hoc per-bit T latch enables with a sequenced, collision-free update path.

Parameters:
- WIDTH, 8, bit width of the shared toggle register and of each requester mask.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  global toggle enable; 0 freezes FSM, grant and register.
- clr  input  1  synchronous clear of the toggle register.
- req  input  NREQ  per-requester request level; bit i = requester i.
- mask  input  NREQ*WIDTH  flattened masks; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  NREQ  one-hot, one-cycle completion pulse, registered.
- q  output  WIDTH  shared toggle register state.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, on rst.
- Reset values: q=0, gnt=0, ack=0, busy=0, state=IDLE, priority pointer=0, captured mask=0.
- FSM states: IDLE, GRANT, APPLY.
  - IDLE: if enable=1 and req!=0, select the winner, load gnt, capture the winner's mask, go to GRANT. Otherwise stay.
  - GRANT: gnt held. If enable=1: q <= q ^ captured mask, ack[winner] <= 1, gnt <= 0, pointer <= (winner+1) mod NREQ, go to APPLY. If enable=0: stall, holding gnt and the captured mask.
  - APPLY: ack visible this cycle only and cleared next edge. If enable=1 and req (winner bit excluded) != 0, arbitrate again and go directly to GRANT (back-to-back). Else go to IDLE. If enable=0: ack still clears and the FSM goes to IDLE.
- Arbitration: round-robin starting at the pointer, searching upward with wrap; the first set req bit wins.
  - Pointer changes only on a completed APPLY.
  - The winner of the previous transaction is lowest priority on the next.
- Latency: req sampled at edge k (IDLE) -> gnt high after edge k -> q updated and ack high after edge k+1. Two cycles per transaction; sustained throughput is one update per 2 cycles.
- Mask is captured at grant; changes to mask or deassertion of req after grant do not affect the applied value, and the transaction always completes.
- Requesters hold req until ack. A req still high in the cycle after ack is treated as a new request.
- Zero mask: the transaction completes normally with ack, and q is unchanged.
- clr:
  - q <= 0 at the next edge in any state, with priority over the toggle update.
  - If clr coincides with the GRANT->APPLY edge, q=0 and ack is still issued.
  - FSM and pointer are unaffected.
- enable=0: q holds except when clr is asserted; no new grants are issued.
- rst mid-transaction: everything returns immediately to reset values, the pending transaction is dropped, and no ack is issued.
- gnt and ack are never both nonzero in the same cycle, and each has at most one bit set.

Test Plan:
- Reset / single request: hold rst, then release; req=0001, mask0=8'h0F, enable=1 -> gnt=0001 one cycle later, then ack=0001 and q=8'h0F; a second identical request gives q=8'h00.
- Round-robin fairness: req=1111 held continuously, with mask_i = 1<<i -> grant order 0,1,2,3,0 in back-to-back 2-cycle slots; q toggles bits 0..3 in turn, ending at 8'h0F after four transactions.
- Enable stall: grant requester 2, then drop enable for 3 cycles during GRANT -> gnt=0100 held, q and ack unchanged; restore enable -> ack=0100 and q ^= mask2 on the next edge.
- Mask change after grant: grant with mask1=8'hAA, change mask1 to 8'h55 during GRANT -> q ^= 8'hAA.
- clr collision: q=8'hFF, clr asserted on the GRANT->APPLY edge with mask=8'h01 -> q=8'h00 and ack still pulses.
- Async reset mid-op: assert rst during GRANT, between clock edges -> gnt, ack, busy and q go to 0 immediately with no ack; after release, req=0010 is granted first because the pointer has reset to 0 and req0 is low.
